// File: rtl/seq_word_serializer.sv
// Parallel-to-serial front end for the sequence detector: a one-word holding
// register feeds a shift register so back-to-back words stream without gaps.
module seq_word_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] hold_r;
  logic             hold_full_r;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    cnt_r;
  logic             seq_r;
  logic             bit_valid_r;
  logic             word_done_r;
  logic             busy_r;

  logic in_shift_s;
  logic at_last_s;
  logic step_s;
  logic accept_s;
  logic transfer_s;
  logic hold_full_nxt_s;

  // Bit currently presented to the detector for a given shift-register image.
  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return v[WIDTH-1];
    end else begin
      return v[0];
    end
  endfunction

  // Moves the next bit of the word into the presented position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  // Reset gates load_ready so nothing is offered while the block is held in reset.
  assign load_ready = reset & ~hold_full_r;

  assign sequence_out = seq_r;
  assign bit_valid    = bit_valid_r;
  assign word_done    = word_done_r;
  assign busy         = busy_r;

  // Handshake and hold->shift transfer decisions for the coming edge.
  always_comb begin
    in_shift_s      = (state_r == ST_SHIFT);
    at_last_s       = in_shift_s && (cnt_r == LAST_C);
    step_s          = in_shift_s && shift_en;
    accept_s        = load_valid && load_ready;
    transfer_s      = hold_full_r && (!in_shift_s || (step_s && at_last_s));
    hold_full_nxt_s = accept_s || (hold_full_r && !transfer_s);
  end

  // Serializer FSM; outputs are registered alongside the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      shift_r     <= '0;
      cnt_r       <= '0;
      seq_r       <= IDLE_LEVEL;
      bit_valid_r <= 1'b0;
      word_done_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        hold_r <= data_in;
      end
      hold_full_r <= hold_full_nxt_s;

      if (transfer_s) begin
        // The held word takes over immediately, so streaming leaves no idle bit.
        state_r     <= ST_SHIFT;
        shift_r     <= hold_r;
        cnt_r       <= '0;
        seq_r       <= lead_bit(hold_r);
        bit_valid_r <= 1'b1;
        word_done_r <= (LAST_C == {CW{1'b0}});
        busy_r      <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            seq_r       <= IDLE_LEVEL;
            bit_valid_r <= 1'b0;
            word_done_r <= 1'b0;
            busy_r      <= hold_full_nxt_s;
          end
          ST_SHIFT: begin
            if (!shift_en) begin
              busy_r <= 1'b1;
            end else if (!at_last_s) begin
              cnt_r       <= cnt_r + CW'(1);
              shift_r     <= advance(shift_r);
              seq_r       <= lead_bit(advance(shift_r));
              bit_valid_r <= 1'b1;
              word_done_r <= ((cnt_r + CW'(1)) == LAST_C);
              busy_r      <= 1'b1;
            end else begin
              state_r     <= ST_IDLE;
              seq_r       <= IDLE_LEVEL;
              bit_valid_r <= 1'b0;
              word_done_r <= 1'b0;
              busy_r      <= hold_full_nxt_s;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            seq_r       <= IDLE_LEVEL;
            bit_valid_r <= 1'b0;
            word_done_r <= 1'b0;
            busy_r      <= hold_full_nxt_s;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_word_serializer.sv
// Bench for seq_word_serializer: directed scenarios plus random traffic checked
// against a bit-queue reference model.
module tb_seq_word_serializer;

  localparam int W = 8;

  logic         clock      = 1'b0;
  logic         reset      = 1'b0;
  logic [W-1:0] data_in    = '0;
  logic         load_valid = 1'b0;
  logic         shift_en   = 1'b0;
  logic         load_ready, sequence_out, bit_valid, word_done, busy;

  logic [W-1:0] l_data  = '0;
  logic         l_valid = 1'b0;
  logic         l_shift = 1'b0;
  logic         l_ready, l_seq, l_bv, l_wd, l_busy;

  int total = 0;
  int bad   = 0;

  // Reference model: bits still to be presented for the current word, plus the holding slot.
  bit           m_hold_full = 1'b0;
  logic [W-1:0] m_hold      = '0;
  bit           m_bits[$];
  bit           m_acc       = 1'b0;
  bit           exp_stream[$];
  bit           got_stream[$];

  seq_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .shift_en(shift_en), .sequence_out(sequence_out),
    .bit_valid(bit_valid), .word_done(word_done), .busy(busy)
  );

  seq_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .data_in(l_data), .load_valid(l_valid),
    .load_ready(l_ready), .shift_en(l_shift), .sequence_out(l_seq),
    .bit_valid(l_bv), .word_done(l_wd), .busy(l_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold_full = 1'b0;
    m_bits.delete();
    exp_stream.delete();
    got_stream.delete();
  endtask

  task automatic model_check();
    bit act;
    act = (m_bits.size() != 0);
    check("sequence_out", 32'(sequence_out), act ? 32'(m_bits[0]) : 32'd0);
    check("bit_valid",    32'(bit_valid),    32'(act));
    check("word_done",    32'(word_done),    32'(m_bits.size() == 1));
    check("busy",         32'(busy),         32'(act || m_hold_full));
    check("load_ready",   32'(load_ready),   32'(reset && !m_hold_full));
  endtask

  task automatic model_update();
    m_acc = reset && load_valid && !m_hold_full;
    if (!reset) begin
      m_hold_full = 1'b0;
      m_bits.delete();
    end else begin
      if (m_bits.size() != 0 && shift_en) m_bits.delete(0);
      if (m_bits.size() == 0 && m_hold_full) begin
        for (int i = 0; i < W; i++) m_bits.push_back(m_hold[W-1-i]);
        m_hold_full = 1'b0;
      end
      if (m_acc) begin
        m_hold      = data_in;
        m_hold_full = 1'b1;
        for (int i = 0; i < W; i++) exp_stream.push_back(data_in[W-1-i]);
      end
    end
  endtask

  // One clock: check outputs on the falling edge, advance the model on the rising edge.
  task automatic tick();
    @(negedge clock);
    model_check();
    if (bit_valid && shift_en) got_stream.push_back(sequence_out);
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n = 0;
    data_in    = w;
    load_valid = 1'b1;
    m_acc      = 1'b0;
    while (!m_acc && n < 64) begin
      tick();
      n++;
    end
    check("send_accepted", 32'(m_acc), 32'd1);
    load_valid = 1'b0;
    data_in    = '0;
  endtask

  task automatic drain();
    int n = 0;
    shift_en = 1'b1;
    while ((m_bits.size() != 0 || m_hold_full) && n < 80) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic stream_check(input string tag);
    check({tag, "_len"}, 32'(got_stream.size()), 32'(exp_stream.size()));
    for (int i = 0; i < exp_stream.size() && i < got_stream.size(); i++)
      check({tag, "_bit"}, 32'(got_stream[i]), 32'(exp_stream[i]));
    exp_stream.delete();
    got_stream.delete();
  endtask

  initial begin
    int n;
    #2;
    check("rst_seq",   32'(sequence_out), 32'd0);
    check("rst_valid", 32'(bit_valid),    32'd0);
    check("rst_done",  32'(word_done),    32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_ready", 32'(load_ready),   32'd0);
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("ready_after_rst", 32'(load_ready), 32'd1);

    // Single word, continuous shifting
    shift_en = 1'b1;
    send(8'hB6);
    drain();
    stream_check("b6");

    // Back-to-back words stream without a gap
    send(8'hF0);
    send(8'h0F);
    drain();
    stream_check("f0_0f");

    // Stalls hold each bit
    shift_en = 1'b1;
    send(8'hA5);
    for (int i = 0; i < 20; i++) begin
      shift_en = (i % 2 == 0);
      tick();
    end
    drain();
    stream_check("a5_stall");

    // Three queued words
    send(8'h11);
    send(8'h22);
    send(8'h33);
    drain();
    stream_check("three");

    // LSB-first instance, word 8'h01
    l_shift = 1'b1;
    l_data  = 8'h01;
    l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    check("lsb_busy_held", 32'(l_busy),  32'd1);
    check("lsb_not_yet",   32'(l_bv),    32'd0);
    check("lsb_ready_low", 32'(l_ready), 32'd0);
    tick();
    for (int i = 0; i < W; i++) begin
      check("lsb_seq",   32'(l_seq), 32'(i == 0));
      check("lsb_valid", 32'(l_bv),  32'd1);
      check("lsb_done",  32'(l_wd),  32'(i == W - 1));
      tick();
    end
    check("lsb_idle_valid", 32'(l_bv),   32'd0);
    check("lsb_idle_busy",  32'(l_busy), 32'd0);
    check("lsb_idle_seq",   32'(l_seq),  32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      load_valid = 1'($urandom_range(0, 1));
      data_in    = W'($urandom);
      shift_en   = ($urandom_range(0, 3) != 0);
      tick();
    end
    load_valid = 1'b0;
    drain();
    stream_check("random");

    // Reset in the middle of a word
    shift_en = 1'b1;
    send(8'h5A);
    n = 0;
    while (got_stream.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    check("mid_bits_seen", 32'(got_stream.size()), 32'd3);
    reset = 1'b0;
    #1;
    check("mid_rst_seq",   32'(sequence_out), 32'd0);
    check("mid_rst_valid", 32'(bit_valid),    32'd0);
    check("mid_rst_done",  32'(word_done),    32'd0);
    check("mid_rst_busy",  32'(busy),         32'd0);
    check("mid_rst_ready", 32'(load_ready),   32'd0);
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_ready_after", 32'(load_ready), 32'd1);
    send(8'h81);
    drain();
    stream_check("post_rst_81");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_word_serializer.md
Name: seq_word_serializer

Overview:
Parallel-to-serial front end for the sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on sequence_out, which drives the detector's sequence_in. A one-word holding register lets back-to-back words stream with no idle bit between them.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_LEVEL, 0, value driven on sequence_out while no word is being shifted.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
data_in  input  WIDTH  word to serialize; sampled on accept.
load_valid  input  1  data_in is valid.
load_ready  output  1  holding register can take a word.
shift_en  input  1  advance one bit this cycle; 0 = stall.
sequence_out  output  1  serial bit to the detector.
bit_valid  output  1  sequence_out carries a word bit.
word_done  output  1  the last bit of a word is presented this cycle.
busy  output  1  a word is shifting or held.

Behaviour:
- Reset (reset=0, async): state=IDLE, hold_full=0, counter=0, shift and hold registers cleared. sequence_out=IDLE_LEVEL, bit_valid=0, word_done=0, busy=0, load_ready=0 while reset is low.
- After reset deasserts: load_ready = ~hold_full, combinational from the register only, with no path from load_valid.
- Accept: load_valid & load_ready at a rising edge writes data_in to hold and sets hold_full.
- Transfer hold->shift occurs at an edge when hold_full=1 and either:
  - state=IDLE, or
  - state=SHIFT & shift_en=1 & counter=WIDTH-1.
  - On transfer: shift register <= hold, counter <= 0, state <= SHIFT, hold_full cleared unless a new accept happens at the same edge. Accept and transfer at the same edge are legal; hold takes the new word and hold_full stays 1.
- FSM:
  - IDLE -> SHIFT on transfer.
  - SHIFT, shift_en=1, counter<WIDTH-1: counter+1 and the shift register moves to the next bit.
  - SHIFT, shift_en=1, counter=WIDTH-1: transfer if hold_full, else -> IDLE.
  - SHIFT, shift_en=0: all state held, outputs unchanged.
- Outputs are decoded from registers only:
  - sequence_out = current bit (shift[WIDTH-1] if MSB_FIRST, else shift[0]) in SHIFT; IDLE_LEVEL in IDLE.
  - bit_valid = (state==SHIFT).
  - word_done = SHIFT & counter==WIDTH-1, high for as many cycles as shift_en stalls the last bit.
  - busy = (state==SHIFT) | hold_full.
- Latency: word accepted at edge k while IDLE -> transferred at edge k+1 -> first bit visible after edge k+1. Each bit is held for exactly one shift_en=1 cycle.
- Streaming: with hold_full at the last bit, the next word's first bit follows the last bit with no gap and bit_valid stays 1.
- Bits are never dropped or duplicated. data_in is ignored whenever load_ready=0.
- Reset mid-word: immediate return to reset values; any partial word and any held word are discarded.
- Counter width is clog2(WIDTH), and the counter never exceeds WIDTH-1.

Test Plan:
1. Reset, then one word 8'hB6 with MSB_FIRST=1 and shift_en=1 held -> sequence_out 1,0,1,1,0,1,1,0 on 8 consecutive cycles. bit_valid=1 for exactly those 8 cycles. word_done=1 only on the 8th. Then IDLE_LEVEL and busy=0.
2. Back-to-back: accept 8'hF0, then 8'h0F while the first word shifts -> 16 contiguous bits 1111000000001111. bit_valid never drops. load_ready=0 from the second accept until the second word transfers.
3. Stall: toggle shift_en 1,0,1,0 during word 8'hA5 -> each bit held through its shift_en=0 cycles. Bit order is unchanged and exactly 8 bits are produced.
4. MSB_FIRST=0, word 8'h01 -> first bit 1, then seven 0s. word_done coincides with the 8th bit.
5. Accept at the same edge as transfer (hold full, last bit, new load_valid) -> the new word is captured, hold_full stays 1, and no word is lost across three queued words.
6. Assert reset low mid-word (after 3 bits), release after 2 cycles -> outputs at reset values immediately. load_ready=1 after release. A new word 8'h81 then serializes cleanly as 1,0,0,0,0,0,0,1.
